keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/sync2.sv | 28 ++
 rtl/keypad_scanner.sv | 160 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, key codes and the
// row/column to key-code table.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } state_t;

   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   // Indexed [row][column]; row = LINE bit driven low, column = COLLUMMN bit low.
   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'd1,     4'd2, 4'd3,     KEY_A},
      '{4'd4,     4'd5, 4'd6,     KEY_B},
      '{4'd7,     4'd8, 4'd9,     KEY_C},
      '{KEY_STAR, 4'd0, KEY_HASH, KEY_D}
   };

   // Lowest active-low column wins when several are pressed together.
   function automatic logic [1:0] lowest_col(input logic [3:0] cols);
      logic [1:0] idx;
      idx = 2'd3;
      if (!cols[0])
         idx = 2'd0;
      else if (!cols[1])
         idx = 2'd1;
      else if (!cols[2])
         idx = 2'd2;
      return idx;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; reset value selectable so that
// idle (pulled-up) lines come out of reset inactive.
module sync2 #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row strobe, debounces press and
// release on the synchronized columns, and reports one pulse per accepted key.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 5000,
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] LINE,
   input  logic [3:0] COLLUMMN,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

   logic [3:0]       w_col_s;
   logic             w_any_low;
   logic             w_match;
   logic [1:0]       w_col_idx;

   state_t           r_state;
   logic [DIV_W-1:0] r_div;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_line;
   logic [1:0]       r_row;
   logic [3:0]       r_cap;
   logic [3:0]       r_code;
   logic             r_valid;
   logic             r_held;

   state_t           w_state_next;
   logic [DIV_W-1:0] w_div_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic [3:0]       w_line_next;
   logic [1:0]       w_row_next;
   logic [3:0]       w_cap_next;
   logic [3:0]       w_code_next;
   logic             w_valid_next;
   logic             w_held_next;
   logic [CNT_W-1:0] w_cnt_inc;

   sync2 #(
      .WIDTH   (4),
      .RST_VAL (4'b1111)
   ) u_col_sync (
      .clk (clk),
      .rst (rst),
      .i_d (COLLUMMN),
      .o_q (w_col_s)
   );

   assign w_any_low = (w_col_s != 4'b1111);
   assign w_match   = (w_col_s == r_cap);
   assign w_col_idx = lowest_col(r_cap);
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_SCAN;
         r_div   <= '0;
         r_cnt   <= '0;
         r_line  <= 4'b1110;
         r_row   <= 2'd0;
         r_cap   <= 4'b1111;
         r_code  <= 4'd0;
         r_valid <= 1'b0;
         r_held  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_div   <= w_div_next;
         r_cnt   <= w_cnt_next;
         r_line  <= w_line_next;
         r_row   <= w_row_next;
         r_cap   <= w_cap_next;
         r_code  <= w_code_next;
         r_valid <= w_valid_next;
         r_held  <= w_held_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_div_next   = r_div;
      w_cnt_next   = r_cnt;
      w_line_next  = r_line;
      w_row_next   = r_row;
      w_cap_next   = r_cap;
      w_code_next  = r_code;
      w_valid_next = 1'b0;
      w_held_next  = r_held;

      case (r_state)
         ST_SCAN: begin
            // A low column freezes the row (divider included) so that the
            // key is debounced against the row that revealed it.
            if (w_any_low) begin
               w_cap_next   = w_col_s;
               w_cnt_next   = '0;
               w_state_next = ST_DEBOUNCE;
            end else if (r_div == DIV_LAST) begin
               w_div_next  = '0;
               w_line_next = {r_line[2:0], r_line[3]};
               w_row_next  = r_row + 2'd1;
            end else begin
               w_div_next = r_div + DIV_W'(1);
            end
         end

         ST_DEBOUNCE: begin
            if (!w_match) begin
               w_state_next = ST_SCAN;
            end else if (r_cnt == CNT_LAST) begin
               w_state_next = ST_HELD;
               w_code_next  = KEY_MAP[r_row][w_col_idx];
               w_valid_next = 1'b1;
               w_held_next  = 1'b1;
            end else begin
               w_cnt_next = w_cnt_inc;
            end
         end

         ST_HELD: begin
            if (!w_any_low) begin
               w_cnt_next   = '0;
               w_state_next = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            if (w_any_low) begin
               w_state_next = ST_HELD;
            end else if (r_cnt == CNT_LAST) begin
               w_state_next = ST_SCAN;
               w_held_next  = 1'b0;
            end else begin
               w_cnt_next = w_cnt_inc;
            end
         end

         default: begin
            w_state_next = ST_SCAN;
         end
      endcase
   end

   assign LINE      = r_line;
   assign key_code  = r_code;
   assign key_valid = r_valid;
   assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural key matrix drives COLLUMMN from LINE,
// and a scoreboard matches every key_valid pulse against expected code and cycle.
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] LINE;
   logic [3:0] COLLUMMN;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [3:0] press_mask [4];
   int         cyc      = 0;
   int         n_checks = 0;
   int         n_errors = 0;

   typedef struct {
      logic [3:0] code;
      int         due;
   } exp_t;
   exp_t sb [$];

   keypad_scanner #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .LINE      (LINE),
      .COLLUMMN  (COLLUMMN),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // A pressed key pulls its column low only while its row is driven.
   always_comb begin
      COLLUMMN = 4'b1111;
      for (int r = 0; r < 4; r++)
         if (!LINE[r])
            COLLUMMN = COLLUMMN & ~press_mask[r];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [3:0] line_of(input int r);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << r);
   endfunction

   task automatic wait_until(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns the first posedge that samples a low column.
   task automatic find_press(output int n);
      n = -1;
      for (int i = 0; i < 64 && n < 0; i++) begin
         #1;
         if (COLLUMMN != 4'b1111)
            n = cyc + 1;
         else
            @(negedge clk);
      end
      check_eq("press_seen", {31'd0, (n >= 0)}, 32'd1);
   endtask

   task automatic press_key(input int r, input logic [3:0] mask, output int n);
      @(negedge clk);
      for (int i = 0; i < 64 && !LINE[r]; i++)
         @(negedge clk);
      press_mask[r] = mask;
      find_press(n);
   endtask

   task automatic expect_press(input int r, input logic [3:0] mask, input logic [3:0] code);
      int n;
      press_key(r, mask, n);
      sb.push_back('{code, n + 2 + DEB});
      wait_until(n + 2 + DEB);
      check_eq("held_after_press", key_held, 1);
      check_eq("code_after_press", key_code, code);
   endtask

   task automatic release_all(input logic [3:0] code);
      int n;
      @(negedge clk);
      for (int r = 0; r < 4; r++)
         press_mask[r] = 4'b0000;
      n = cyc + 1;
      wait_until(n + 1 + DEB);
      check_eq("held_before_release", key_held, 1);
      wait_until(n + 2 + DEB);
      check_eq("held_after_release", key_held, 0);
      check_eq("code_kept", key_code, code);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Scoreboard side: every key_valid pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (key_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_valid", {31'd0, key_valid}, 32'd0);
            end else begin
               e = sb.pop_front();
               $display("key_valid code %0d at cycle %0d (expected code %0d at cycle %0d)",
                        key_code, cyc, e.code, e.due);
               check_eq("valid_code", key_code, e.code);
               check_eq("valid_cycle", cyc, e.due);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "bench timed out");
   end

   initial begin
      int n;
      for (int r = 0; r < 4; r++)
         press_mask[r] = 4'b0000;

      // Reset values and idle rotation
      repeat (3) @(negedge clk);
      check_eq("rst_line", LINE, 4'b1110);
      check_eq("rst_code", key_code, 0);
      check_eq("rst_valid", key_valid, 0);
      check_eq("rst_held", key_held, 0);
      rst = 1'b0;
      check_eq("idle_line", LINE, 4'b1110);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         check_eq("idle_line", LINE, line_of((k / SCAN_DIV) % 4));
      end

      // Row 2 / column 1 -> 8, held then released
      expect_press(2, 4'b0010, 4'd8);
      repeat (15) @(posedge clk);
      #1;
      check_eq("held_long", key_held, 1);
      release_all(4'd8);

      // Bounce on row 0 / column 0 right after reset
      do_reset();
      press_mask[0] = 4'b0001;
      repeat (3) @(negedge clk);
      press_mask[0] = 4'b0000;
      @(negedge clk);
      press_mask[0] = 4'b0001;
      n = cyc + 1;
      sb.push_back('{4'd1, n + 2 + DEB});
      wait_until(n + 2 + DEB);
      check_eq("bounce_held", key_held, 1);
      check_eq("bounce_code", key_code, 1);
      release_all(4'd1);

      // Two columns on row 3: lowest column wins
      expect_press(3, 4'b0011, KEY_STAR);
      release_all(KEY_STAR);

      // Second key while held is ignored
      expect_press(1, 4'b0010, 4'd5);
      @(negedge clk);
      press_mask[1] = 4'b1010;
      press_mask[0] = 4'b0001;
      repeat (20) @(posedge clk);
      #1;
      check_eq("second_held", key_held, 1);
      check_eq("second_code", key_code, 5);
      release_all(4'd5);

      // Reset in the middle of debounce, key kept pressed
      do_reset();
      press_key(1, 4'b0100, n);
      wait_until(n + 2 + 5);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("abort_valid", key_valid, 0);
      check_eq("abort_held", key_held, 0);
      check_eq("abort_code", key_code, 0);
      check_eq("abort_line", LINE, 4'b1110);
      @(negedge clk);
      rst = 1'b0;
      find_press(n);
      sb.push_back('{4'd6, n + 2 + DEB});
      wait_until(n + 2 + DEB);
      check_eq("repress_held", key_held, 1);
      check_eq("repress_code", key_code, 6);
      release_all(4'd6);

      repeat (20) @(posedge clk);
      #1;
      check_eq("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
